calc2_port_master: RTL
======================

# calc2_port_master

Upstream request master for one calc2 port: accepts whole operations (command plus two operands) over a valid/ready handshake and serialises each into calc2's two-cycle request protocol with an allocated 2-bit tag. It captures calc2 responses by tag and returns results to the client strictly in issue order, with backpressure. One instance sits in front of each of the four calc2 request/response port pairs, all on the same `c_clk`/`reset` as calc2.

## Interface
- `DATA_W`, default 32: operand and result width.
- `c_clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 1: client operation valid.
- `req_ready`, output, 1: operation accepted when `req_valid & req_ready` at a rising edge.
- `req_cmd`, input, 4: calc2 command.
- `req_op1`, input, DATA_W: first operand.
- `req_op2`, input, DATA_W: second operand.
- `cmd_out`, output, 4: drives calc2 `reqN_cmd_in`.
- `data_out`, output, DATA_W: drives calc2 `reqN_data_in`.
- `tag_out`, output, 2: drives calc2 `reqN_tag_in`.
- `dut_resp`, input, 2: from calc2 `out_respN`.
- `dut_data`, input, DATA_W: from calc2 `out_dataN`.
- `dut_tag`, input, 2: from calc2 `out_tagN`.
- `rsp_valid`, output, 1: in-order result available.
- `rsp_ready`, input, 1: client consumes the result.
- `rsp_data`, output, DATA_W: result data.
- `rsp_resp`, output, 2: calc2 response code.
- `rsp_cmd`, output, 4: command that produced the result.
- `inflight`, output, 3: occupied slots, 0 to 4.
- `err_spurious`, output, 1: sticky flag for an unexpected response.

## Operation
- Four slots, one per tag. Slot state is FREE, PEND or DONE. Each slot stores cmd, data and resp.
- Tags are allocated round-robin through `alloc_ptr`, which wraps 3→0. Results are delivered through `head_ptr`, which also wraps.
- Issue FSM has two states, IDLE and OP2.
  - `req_ready` = (state==IDLE) & (slot[alloc_ptr]==FREE) & !reset.
  - On accept: slot[alloc_ptr] ← PEND, store cmd, `alloc_ptr`++, go to OP2.
  - OP2 always returns to IDLE after one cycle.
- Any command value is forwarded unchanged; invalid commands are calc2's concern.
- Response capture happens when `dut_resp != 0`:
  - If slot[dut_tag]==PEND: store data and resp, state ← DONE.
  - Otherwise (FREE or DONE): drop the data and set `err_spurious`, which stays set until reset.
- Delivery:
  - `rsp_valid` = (slot[head_ptr]==DONE). `rsp_*` show that slot's contents and stay stable while `rsp_ready` is low.
  - On `rsp_valid & rsp_ready`: slot ← FREE, `head_ptr`++.
- `inflight` = number of non-FREE slots.
- Simultaneous events:
  - Pop and allocate in the same cycle use register state, so a slot freed by a pop is allocatable on the next cycle.
  - Capture to one slot and pop of another in the same cycle are independent.
- Reset values: all slots FREE, both pointers 0, state IDLE, and `cmd_out`, `data_out`, `tag_out`, `rsp_valid`, `inflight`, `err_spurious` all 0.
- Reset asserted mid-operation abandons all in-flight work. calc2 shares the same reset.

## Timing
- Accept at edge T (registered outputs):
  - After T: `cmd_out`=cmd, `data_out`=op1, `tag_out`=tag.
  - After T+1: `cmd_out`=0, `data_out`=op2, `tag_out`=tag.
  - After T+2: `cmd_out`=0 unless a new operation was accepted at T+2.
- Throughput: at most one operation per 2 cycles. `req_ready` is low throughout OP2.
- Response sampled at edge R: `rsp_valid` rises after R if that tag is at the head. The minimum response-to-result latency is 1 cycle.
- calc2 response latency is unbounded. No timeout is implemented.

## Structure
- `calc2_pkg` holds the shared types:
  - `cmd_e`: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6.
  - `resp_e`: NONE=0, OK=1, ERR=2, RSVD=3.
  - `slot_state_e`: FREE, PEND, DONE.
  - `NUM_TAGS`=4.
- Sub-module `calc2_tag_rob`: the 4-slot array with capture, pop, head pointer and occupancy count. The top level holds the issue FSM and the output registers.

## Test plan
- Reset and idle:
  - During reset: all outputs are 0 and `req_ready`=0.
  - Cycle after release: `req_ready`=1, `inflight`=0.
- Single ADD:
  - Stimulus: ADD with op1=5, op2=3 accepted at T.
  - Calc2 side: `cmd_out`=1, `data_out`=5, `tag_out`=0 after T, then `cmd_out`=0, `data_out`=3.
  - Response resp=1, data=8, tag=0 gives `rsp_valid`=1, `rsp_data`=8, `rsp_resp`=1, `rsp_cmd`=1.
- Tag exhaustion:
  - Four operations issued back-to-back use tags 0–3, `inflight`=4, and `req_ready`=0 for a fifth.
  - Popping tag 0 gives `req_ready`=1 on the next cycle, and the fifth operation gets tag 0.
- Reordering:
  - Stimulus: three operations issued, responses arrive for tag 2, then 1, then 0.
  - Results are delivered in tag order 0, 1, 2.
  - With `rsp_ready`=0, `rsp_data` stays stable.
- Overflow:
  - Stimulus: ADD 0xFFFFFFFF + 1, with calc2 returning resp=2.
  - The result is delivered with `rsp_resp`=2.
- Spurious response:
  - Stimulus: `dut_resp`=1, `dut_tag`=3 while slot 3 is FREE.
  - `err_spurious`=1 and stays set; `rsp_valid` stays 0 and `inflight` is unchanged.

Source files
------------

// File: rtl/calc2_pkg.sv
// Shared calc2 types: command/response encodings, tag-slot state and issue FSM states.
package calc2_pkg;

   localparam int unsigned NUM_TAGS = 4;
   localparam int unsigned TAG_W    = 2;
   localparam int unsigned CMD_W    = 4;
   localparam int unsigned RESP_W   = 2;
   localparam int unsigned CNT_W    = 3;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [RESP_W-1:0] {
      RESP_NONE = 2'd0,
      RESP_OK   = 2'd1,
      RESP_ERR  = 2'd2,
      RESP_RSVD = 2'd3
   } resp_e;

   typedef enum logic [1:0] {
      SLOT_FREE = 2'd0,
      SLOT_PEND = 2'd1,
      SLOT_DONE = 2'd2
   } slot_state_e;

   typedef enum logic {
      ISSUE_IDLE = 1'b0,
      ISSUE_OP2  = 1'b1
   } issue_state_e;

   // Per-tag bookkeeping; result data is kept separately because its width is a parameter.
   typedef struct packed {
      slot_state_e       state;
      logic [CMD_W-1:0]  cmd;
      logic [RESP_W-1:0] resp;
   } slot_meta_t;

endpackage

// File: rtl/calc2_port_master_if.sv
// Client-side and calc2-side signals of one calc2 port master.
interface calc2_port_master_if #(parameter int unsigned DATA_W = 32);

   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_cmd;
   logic [DATA_W-1:0] req_op1;
   logic [DATA_W-1:0] req_op2;
   logic [3:0]        cmd_out;
   logic [DATA_W-1:0] data_out;
   logic [1:0]        tag_out;
   logic [1:0]        dut_resp;
   logic [DATA_W-1:0] dut_data;
   logic [1:0]        dut_tag;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [1:0]        rsp_resp;
   logic [3:0]        rsp_cmd;
   logic [2:0]        inflight;
   logic              err_spurious;

   modport master (
      input  req_valid, req_cmd, req_op1, req_op2,
      input  dut_resp, dut_data, dut_tag, rsp_ready,
      output req_ready, cmd_out, data_out, tag_out,
      output rsp_valid, rsp_data, rsp_resp, rsp_cmd, inflight, err_spurious
   );

   modport slave (
      output req_valid, req_cmd, req_op1, req_op2,
      output dut_resp, dut_data, dut_tag, rsp_ready,
      input  req_ready, cmd_out, data_out, tag_out,
      input  rsp_valid, rsp_data, rsp_resp, rsp_cmd, inflight, err_spurious
   );

endinterface

// File: rtl/calc2_tag_rob.sv
// Four-slot tag reorder buffer: response capture by tag, in-order delivery from the head.
module calc2_tag_rob
   import calc2_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_en,
   input  logic [TAG_W-1:0]  alloc_idx,
   input  logic [CMD_W-1:0]  alloc_cmd,
   output logic              alloc_free,
   input  logic [RESP_W-1:0] cap_resp,
   input  logic [TAG_W-1:0]  cap_tag,
   input  logic [DATA_W-1:0] cap_data,
   input  logic              pop_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [RESP_W-1:0] rsp_resp,
   output logic [CMD_W-1:0]  rsp_cmd,
   output logic [CNT_W-1:0]  inflight,
   output logic              err_spurious
);

   slot_meta_t        meta [NUM_TAGS];
   logic [DATA_W-1:0] data [NUM_TAGS];
   logic [TAG_W-1:0]  head_ptr;
   logic              pop;
   logic [CNT_W-1:0]  occ;

   assign alloc_free = (meta[alloc_idx].state == SLOT_FREE);
   assign rsp_valid  = (meta[head_ptr].state == SLOT_DONE);
   assign rsp_data   = data[head_ptr];
   assign rsp_resp   = meta[head_ptr].resp;
   assign rsp_cmd    = meta[head_ptr].cmd;
   assign pop        = rsp_valid & pop_ready;
   assign inflight   = occ;

   // Alloc needs FREE, capture needs PEND, pop needs DONE, so same-cycle events never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            meta[i] <= '{state: SLOT_FREE, cmd: '0, resp: '0};
            data[i] <= '0;
         end
         head_ptr     <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (alloc_en) begin
            meta[alloc_idx].state <= SLOT_PEND;
            meta[alloc_idx].cmd   <= alloc_cmd;
            meta[alloc_idx].resp  <= RESP_NONE;
         end
         if (cap_resp != RESP_NONE) begin
            if (meta[cap_tag].state == SLOT_PEND) begin
               meta[cap_tag].state <= SLOT_DONE;
               meta[cap_tag].resp  <= cap_resp;
               data[cap_tag]       <= cap_data;
            end else begin
               err_spurious <= 1'b1;
            end
         end
         if (pop) begin
            meta[head_ptr].state <= SLOT_FREE;
            head_ptr             <= head_ptr + TAG_W'(1);
         end
      end
   end

   // Occupancy: count of non-FREE slots.
   always_comb begin
      occ = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (meta[i].state != SLOT_FREE) occ = occ + CNT_W'(1);
      end
   end

endmodule

// File: rtl/calc2_port_master.sv
// calc2 port master: serialises client operations into calc2's two-cycle tagged request protocol.
module calc2_port_master
   import calc2_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                c_clk,
   input  logic                reset,
   calc2_port_master_if.master bus
);

   issue_state_e      state;
   logic [TAG_W-1:0]  alloc_ptr;
   logic [DATA_W-1:0] op2_q;
   logic              alloc_free;
   logic              accept;

   assign bus.req_ready = (state == ISSUE_IDLE) & alloc_free & ~reset;
   assign accept        = bus.req_valid & bus.req_ready;

   // Issue FSM: op1 with the command on the accept cycle, op2 with cmd 0 on the next.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state        <= ISSUE_IDLE;
         alloc_ptr    <= '0;
         op2_q        <= '0;
         bus.cmd_out  <= '0;
         bus.data_out <= '0;
         bus.tag_out  <= '0;
      end else begin
         case (state)
            ISSUE_IDLE: begin
               if (accept) begin
                  bus.cmd_out  <= bus.req_cmd;
                  bus.data_out <= bus.req_op1;
                  bus.tag_out  <= alloc_ptr;
                  op2_q        <= bus.req_op2;
                  alloc_ptr    <= alloc_ptr + TAG_W'(1);
                  state        <= ISSUE_OP2;
               end else begin
                  bus.cmd_out <= '0;
               end
            end
            ISSUE_OP2: begin
               bus.cmd_out  <= '0;
               bus.data_out <= op2_q;
               state        <= ISSUE_IDLE;
            end
            default: state <= ISSUE_IDLE;
         endcase
      end
   end

   calc2_tag_rob #(.DATA_W(DATA_W)) u_rob (
      .clk          (c_clk),
      .rst          (reset),
      .alloc_en     (accept),
      .alloc_idx    (alloc_ptr),
      .alloc_cmd    (bus.req_cmd),
      .alloc_free   (alloc_free),
      .cap_resp     (bus.dut_resp),
      .cap_tag      (bus.dut_tag),
      .cap_data     (bus.dut_data),
      .pop_ready    (bus.rsp_ready),
      .rsp_valid    (bus.rsp_valid),
      .rsp_data     (bus.rsp_data),
      .rsp_resp     (bus.rsp_resp),
      .rsp_cmd      (bus.rsp_cmd),
      .inflight     (bus.inflight),
      .err_spurious (bus.err_spurious)
   );

endmodule
